valu_resp_buffer: RTL and testbench
===================================

VALU_RESP_BUFFER -- requirements
Module: valu_resp_buffer

Interface
REQ-001 Parameter: DATA_WIDTH, default 64, width of one result beat; must match the bitwise ALU response width.
REQ-002 Parameter: DEPTH, default 8, number of FIFO entries; power of two, 2 or more.
REQ-003 Parameter: CW, default $clog2(DEPTH+1), width of the count and credit counters.
REQ-004 Port: clk  in  1  sole clock; all state on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 Port: in_issue  in  1  upstream issued one beat into the ALU this cycle (one-cycle pulse).
REQ-007 Port: issue_ok  out  1  upstream may issue a beat this cycle.
REQ-008 Port: in_vec  in  DATA_WIDTH  result beat from the ALU.
REQ-009 Port: in_valid  in  1  in_vec is valid; there is no backpressure toward the ALU.
REQ-010 Port: out_vec  out  DATA_WIDTH  head beat toward register-file writeback.
REQ-011 Port: out_valid  out  1  out_vec is valid.
REQ-012 Port: out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-013 Port: count  out  CW  number of beats stored in the FIFO.
REQ-014 Port: ovf_err  out  1  sticky protocol-error flag.

Function
REQ-015 The block SHALL be a DEPTH-entry in-order FIFO with separate read and write pointers that wrap modulo DEPTH; beats SHALL leave in arrival order with no loss or duplication.
REQ-016 The pending counter SHALL increment on in_issue, decrement on in_valid, and stay unchanged when both occur in the same cycle; it SHALL saturate at DEPTH and at 0.
REQ-017 issue_ok SHALL be combinational and equal (count + pending) < DEPTH.
REQ-018 The credit rule SHALL hold for any fixed ALU latency (6 cycles nominal); the block SHALL NOT depend on the latency value.
REQ-019 Write: when in_valid=1 the beat SHALL be stored unless it is bypassed (REQ-031); when full, the write SHALL succeed only if a dequeue occurs in the same cycle.
REQ-020 Read: out_vec SHALL equal the entry at the read pointer; out_valid SHALL be 1 when count is not 0.
REQ-021 A non-bypassed beat arriving in cycle N SHALL be presented at out_vec in cycle N+1 at the earliest.
REQ-022 Once out_valid is 1, out_valid and out_vec SHALL stay stable until the beat is accepted.
REQ-023 A simultaneous write and read SHALL leave count unchanged; this SHALL be legal at full and at count=1.
REQ-024 in_valid while full with no dequeue SHALL drop the beat and set ovf_err.
REQ-025 in_issue while issue_ok=0 SHALL set ovf_err; the issue SHALL still be counted (saturating).
REQ-026 in_valid while pending=0 SHALL set ovf_err (unsolicited beat); the beat SHALL still be written if space exists.
REQ-027 ovf_err SHALL clear only on reset.

Reset
REQ-028 While rst=0: pointers=0, count=0, pending=0, ovf_err=0, out_valid=0; issue_ok SHALL be 1 once reset is released.
REQ-029 FIFO storage contents SHALL NOT be reset; out_vec is don't-care while out_valid=0.
REQ-030 Reset asserted mid-stream SHALL discard all stored and in-flight beats; beats arriving after release without a matching in_issue SHALL be handled per REQ-026.

Configuration
REQ-031 Macro VALU_RESP_BUFFER_BYPASS_EN defined: when count=0 and in_valid=1, out_vec SHALL equal in_vec and out_valid SHALL be 1 in the same cycle.
- If out_ready=1, the beat SHALL NOT be written to the FIFO.
- If out_ready=0, the beat SHALL be written and presented again next cycle from the FIFO, so the presented value stays stable.
REQ-032 Macro not defined: no combinational path from in_vec or in_valid to out_vec or out_valid; minimum latency SHALL be 1 cycle.

Verification
REQ-033 Reset, then 8 in_issue pulses with no dequeue -> issue_ok=0 after the 8th pulse; 6 cycles later 8 beats arrive -> count=8, ovf_err=0.
REQ-034 Full FIFO, out_ready=1 while in_valid=1 with value 0xA5 -> count stays 8; 0xA5 exits last in order.
REQ-035 Full FIFO, out_ready=0, in_valid=1 -> beat dropped, ovf_err=1, count=8.
REQ-036 Bypass build, empty FIFO, out_ready=1, in_vec=0x1234 -> out_valid=1 and out_vec=0x1234 in the same cycle, count stays 0; non-bypass build -> out_valid rises 1 cycle later.
REQ-037 Random 10,000 beats with random out_ready and credit-respecting issue -> output sequence equals input sequence, ovf_err=0.
REQ-038 Assert rst=0 with count=5 and pending=3 -> count=0, out_valid=0 immediately; after release issue_ok=1.

Source files
------------

// File: rtl/valu_resp_buffer_if.sv
// Handshake bundle for valu_resp_buffer: credit issue, ALU result input, writeback output, status.
// master = upstream/consumer side, slave = the buffer.
interface valu_resp_buffer_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CW         = 4
);
  logic                  in_issue;
  logic                  issue_ok;
  logic [DATA_WIDTH-1:0] in_vec;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         count;
  logic                  ovf_err;

  modport master (
    output in_issue, in_vec, in_valid, out_ready,
    input  issue_ok, out_vec, out_valid, count, ovf_err
  );

  modport slave (
    input  in_issue, in_vec, in_valid, out_ready,
    output issue_ok, out_vec, out_valid, count, ovf_err
  );
endinterface

// File: rtl/valu_resp_buffer.sv
// Credit-managed in-order response FIFO between the bitwise ALU and register-file writeback.
// Optional same-cycle bypass when empty: define VALU_RESP_BUFFER_BYPASS_EN.
module valu_resp_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  valu_resp_buffer_if.slave   bus
);
  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         pending;
  logic                  ovf_q;

  logic                  empty;
  logic                  full;
  logic                  fifo_deq;
  logic                  byp_take;
  logic                  wr_en;
  logic                  drop;
  logic [CW:0]           credit_sum;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign fifo_deq = !empty && bus.out_ready;

`ifdef VALU_RESP_BUFFER_BYPASS_EN
  // Bypassed beat only skips storage if consumed now; otherwise it is stored
  // so the same value is re-presented from the FIFO next cycle.
  assign byp_take = empty && bus.in_valid && bus.out_ready;

  always_comb begin
    bus.out_valid = !empty || bus.in_valid;
    bus.out_vec   = empty ? bus.in_vec : mem[rd_ptr];
  end
`else
  assign byp_take = 1'b0;

  always_comb begin
    bus.out_valid = !empty;
    bus.out_vec   = mem[rd_ptr];
  end
`endif

  assign wr_en = bus.in_valid && !byp_take && (!full || fifo_deq);
  assign drop  = bus.in_valid && full && !fifo_deq;

  assign credit_sum   = {1'b0, count_q} + {1'b0, pending};
  assign bus.issue_ok = (credit_sum < (CW + 1)'(DEPTH));
  assign bus.count    = count_q;
  assign bus.ovf_err  = ovf_q;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      if (fifo_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, fifo_deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if (bus.in_issue && !bus.in_valid) begin
      if (pending != FULL_CNT) pending <= pending + 1'b1;
    end else if (!bus.in_issue && bus.in_valid) begin
      if (pending != '0) pending <= pending - 1'b1;
    end
  end

  // Sticky: overflow drop, issue without credit, or beat with no outstanding issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (drop || (bus.in_issue && !bus.issue_ok) ||
                 (bus.in_valid && pending == '0)) begin
      ovf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_valu_resp_buffer.sv
// Directed and scoreboard checks for valu_resp_buffer (DEPTH=8, DATA_WIDTH=64).
module tb_valu_resp_buffer;
  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  valu_resp_buffer_if #(.DATA_WIDTH(64), .CW(4)) bus ();

  valu_resp_buffer #(.DATA_WIDTH(64), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic iss, input logic v, input logic [63:0] d, input logic rdy);
    @(negedge clk);
    bus.in_issue  = iss;
    bus.in_valid  = v;
    bus.in_vec    = d;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0, 0, 64'h0, 0);
    rst = 1'b1;
  endtask

  logic        pv [6];
  logic [63:0] pd [6];
  logic [63:0] exp_q [$];
  logic [63:0] d;
  logic        iss;
  int          got;
  int          sent;
  int          cyc;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b0;
    bus.in_issue = 1'b0; bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b0;

    // Reset state
    step(0, 0, 64'h0, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    rst = 1'b1;
    step(0, 0, 64'h0, 0);
    chk("rst_issue_ok", bus.issue_ok, 1);

    // Eight issues exhaust credit; beats arrive after the ALU latency
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 64'h0, 0);
      if (i == 7) chk("issue_ok_before_8th", bus.issue_ok, 1);
    end
    step(0, 0, 64'h0, 0);
    chk("issue_ok_after_8", bus.issue_ok, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 64'h0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 64'h10 + 64'(i), 0);
`ifndef VALU_RESP_BUFFER_BYPASS_EN
      if (i == 0) chk("no_comb_path", bus.out_valid, 0);
`endif
    end
    step(0, 0, 64'h0, 0);
    chk("full_count", bus.count, 8);
    chk("full_ovf", bus.ovf_err, 0);
    chk("full_head", bus.out_vec, 64'h10);
    chk("full_issue_ok", bus.issue_ok, 0);

    // Full with dequeue: 0xA5 enters as the head leaves (unsolicited: no credit)
    step(0, 1, 64'hA5, 1);
    chk("a5_head", bus.out_vec, 64'h10);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 64'h0, 1);
      if (i == 0) begin
        chk("a5_count", bus.count, 8);
        chk("a5_ovf_unsolicited", bus.ovf_err, 1);
      end
      chk("a5_drain", bus.out_vec, (i < 7) ? 64'h11 + 64'(i) : 64'hA5);
    end
    step(0, 0, 64'h0, 0);
    chk("a5_empty_count", bus.count, 0);
    chk("a5_empty_valid", bus.out_valid, 0);

    // Full without dequeue: beat dropped
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 64'h20 + 64'(i), 0);
    step(0, 0, 64'h0, 0);
    chk("drop_pre_ovf", bus.ovf_err, 0);
    step(0, 1, 64'hEE, 0);
    step(0, 0, 64'h0, 0);
    chk("drop_count", bus.count, 8);
    chk("drop_ovf", bus.ovf_err, 1);
    chk("drop_stable_head", bus.out_vec, 64'h20);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 64'h0, 1);
      chk("drop_drain", bus.out_vec, 64'h20 + 64'(i));
    end
    step(0, 0, 64'h0, 0);
    chk("drop_empty", bus.out_valid, 0);

    // Empty FIFO, consumer ready
    do_reset();
    step(1, 0, 64'h0, 0);
    step(0, 1, 64'h1234, 1);
`ifdef VALU_RESP_BUFFER_BYPASS_EN
    chk("byp_valid", bus.out_valid, 1);
    chk("byp_vec", bus.out_vec, 64'h1234);
    step(0, 0, 64'h0, 1);
    chk("byp_count", bus.count, 0);
`else
    chk("lat_valid_same", bus.out_valid, 0);
    step(0, 0, 64'h0, 1);
    chk("lat_valid_next", bus.out_valid, 1);
    chk("lat_vec_next", bus.out_vec, 64'h1234);
    chk("lat_count", bus.count, 1);
`endif
    step(0, 0, 64'h0, 0);
    chk("lat_drained", bus.count, 0);
    chk("lat_ovf", bus.ovf_err, 0);

    // Simultaneous write and read at count=1
    step(1, 0, 64'h0, 0);
    step(1, 0, 64'h0, 0);
    step(0, 1, 64'hB1, 0);
    step(0, 1, 64'hB2, 1);
    chk("c1_head", bus.out_vec, 64'hB1);
    step(0, 0, 64'h0, 0);
    chk("c1_count", bus.count, 1);
    chk("c1_next", bus.out_vec, 64'hB2);
    chk("c1_ovf", bus.ovf_err, 0);

    // Mid-stream reset with count=5, pending=3
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 64'h40 + 64'(i), 0);
    step(0, 0, 64'h0, 0);
    chk("mid_count5", bus.count, 5);
    chk("mid_issue_ok0", bus.issue_ok, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    step(0, 0, 64'h0, 0);
    rst = 1'b1;
    step(0, 0, 64'h0, 0);
    chk("mid_issue_ok", bus.issue_ok, 1);
    chk("mid_ovf", bus.ovf_err, 0);

    // Issue without credit
    for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 0);
    step(0, 0, 64'h0, 0);
    chk("nocred_ovf_pre", bus.ovf_err, 0);
    step(1, 0, 64'h0, 0);
    step(0, 0, 64'h0, 0);
    chk("nocred_ovf", bus.ovf_err, 1);

    // Unsolicited beat is still stored
    do_reset();
    step(0, 1, 64'h77, 0);
    step(0, 0, 64'h0, 0);
    chk("unsol_ovf", bus.ovf_err, 1);
    chk("unsol_count", bus.count, 1);
    chk("unsol_vec", bus.out_vec, 64'h77);

    // Scoreboard stream: 6-cycle ALU model, random ready, credit-respecting issue
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    got = 0; sent = 0; cyc = 0;
    while (got < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      iss = (sent < 10000) && bus.issue_ok && ($urandom_range(0, 3) != 0);
      d   = {$urandom, $urandom};
      bus.in_valid = pv[5];
      bus.in_vec   = pd[5];
      for (int i = 5; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = iss;
      pd[0] = d;
      if (iss) begin
        exp_q.push_back(d);
        sent++;
      end
      bus.in_issue  = iss;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("rnd_unexpected", 1, 0);
        else chk("rnd_data", bus.out_vec, exp_q.pop_front());
        got++;
      end
    end
    chk("rnd_got", 64'(got), 64'd10000);
    chk("rnd_ovf", bus.ovf_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
